// File: rtl/pbkdf2_key_sched.sv
// PBKDF2 key schedule controller.
// Sequences the blocks T_1..T_n of a PBKDF2 derived key: launches the
// downstream chunk engine once per block with {salt, big-endian index},
// captures each 256-bit result and streams it out MSB word first.
// The last block is truncated so that exactly dklen 32-bit words leave.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both 1. A producer holds valid and its payload stable until that
// edge; ready may depend combinationally on valid. Here the chunk result
// uses chunk_valid_i/chunk_ready_o and the key stream uses
// key_valid_o/key_ready_i.
module pbkdf2_key_sched #(
  parameter int MAX_BLOCKS = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [255:0] pass_i,
  input  logic [223:0] salt_i,
  input  logic [31:0]  iters_i,
  input  logic [7:0]   dklen_i,
  output logic         chunk_start_o,
  output logic [255:0] chunk_pass_o,
  output logic [255:0] chunk_salt_o,
  output logic [31:0]  chunk_iters_o,
  input  logic         chunk_valid_i,
  input  logic [255:0] chunk_hash_i,
  output logic         chunk_ready_o,
  output logic         key_valid_o,
  output logic [31:0]  key_word_o,
  output logic         key_last_o,
  input  logic         key_ready_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [2:0]   state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [31:0] MAX_WORDS = 32'(8 * MAX_BLOCKS);

  state_e        state_q, state_d;
  logic [255:0]  pass_q;
  logic [223:0]  salt_q;
  logic [31:0]   iters_q;
  logic [7:0]    dklen_q;
  logic [31:0]   blk_idx_q;
  logic [7:0]    word_cnt_q;
  logic [255:0]  hold_q;
  logic          err_q;

  logic start_bad;
  logic start_ok;
  logic start_rej;
  logic word_acc;
  logic last_word;
  logic blk_end;

  // A zero-length key, a key longer than MAX_BLOCKS blocks, or zero
  // iterations cannot be derived; such starts are refused outright.
  assign start_bad = (dklen_i == 8'd0) || ({24'd0, dklen_i} > MAX_WORDS) ||
                     (iters_i == 32'd0);
  assign start_ok  = (state_q == S_IDLE) && start_i && !start_bad;
  assign start_rej = (state_q == S_IDLE) && start_i && start_bad;

  assign word_acc  = key_valid_o && key_ready_i;
  assign last_word = (word_cnt_q == dklen_q - 8'd1);
  assign blk_end   = (word_cnt_q[2:0] == 3'd7);

  // State register; reset abandons any derivation in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (chunk_valid_i) state_d = S_DRAIN;
      S_DRAIN: begin
        if (word_acc) begin
          if (last_word)    state_d = S_DONE;
          else if (blk_end) state_d = S_ISSUE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latched request, block index, word counter, result hold and error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pass_q     <= '0;
      salt_q     <= '0;
      iters_q    <= '0;
      dklen_q    <= '0;
      blk_idx_q  <= '0;
      word_cnt_q <= '0;
      hold_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= start_rej;
      if (start_ok) begin
        pass_q     <= pass_i;
        salt_q     <= salt_i;
        iters_q    <= iters_i;
        dklen_q    <= dklen_i;
        blk_idx_q  <= 32'd1;
        word_cnt_q <= 8'd0;
      end
      if ((state_q == S_WAIT) && chunk_valid_i) begin
        hold_q <= chunk_hash_i;
      end
      if ((state_q == S_DRAIN) && word_acc) begin
        word_cnt_q <= word_cnt_q + 8'd1;
        if (!last_word && blk_end) begin
          blk_idx_q <= blk_idx_q + 32'd1;
        end
      end
    end
  end

  // Word k of a block (k = 0 first) sits at hold[255-32k -: 32], i.e. at
  // base 32*(7-k), and 7-k is the bitwise inverse of k in three bits.
  always_comb begin
    key_word_o = '0;
    if (state_q == S_DRAIN) begin
      key_word_o = hold_q[{~word_cnt_q[2:0], 5'd0} +: 32];
    end
  end

  assign chunk_start_o = (state_q == S_ISSUE);
  assign chunk_pass_o  = pass_q;
  assign chunk_salt_o  = {salt_q, blk_idx_q};
  assign chunk_iters_o = iters_q;
  assign chunk_ready_o = (state_q == S_WAIT) && chunk_valid_i;
  assign key_valid_o   = (state_q == S_DRAIN);
  assign key_last_o    = (state_q == S_DRAIN) && last_word;
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = (state_q == S_DONE);
  assign err_o         = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pbkdf2_key_sched.sv
// Bench for pbkdf2_key_sched: a transaction-level model predicts every
// output each cycle, plus directed literal checks per scenario.
module tb_pbkdf2_key_sched;

  localparam int MAX_BLOCKS = 4;
  localparam logic [255:0] FIXED_HASH =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  // clock / reset
  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic         rst_ni;
  logic         start_i;
  logic [255:0] pass_i;
  logic [223:0] salt_i;
  logic [31:0]  iters_i;
  logic [7:0]   dklen_i;
  logic         chunk_start_o;
  logic [255:0] chunk_pass_o;
  logic [255:0] chunk_salt_o;
  logic [31:0]  chunk_iters_o;
  logic         chunk_valid_i;
  logic [255:0] chunk_hash_i;
  logic         chunk_ready_o;
  logic         key_valid_o;
  logic [31:0]  key_word_o;
  logic         key_last_o;
  logic         key_ready_i;
  logic         busy_o;
  logic         done_o;
  logic         err_o;
  logic [2:0]   state_dbg;

  pbkdf2_key_sched #(.MAX_BLOCKS(MAX_BLOCKS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .pass_i(pass_i),
    .salt_i(salt_i), .iters_i(iters_i), .dklen_i(dklen_i),
    .chunk_start_o(chunk_start_o), .chunk_pass_o(chunk_pass_o),
    .chunk_salt_o(chunk_salt_o), .chunk_iters_o(chunk_iters_o),
    .chunk_valid_i(chunk_valid_i), .chunk_hash_i(chunk_hash_i),
    .chunk_ready_o(chunk_ready_o), .key_valid_o(key_valid_o),
    .key_word_o(key_word_o), .key_last_o(key_last_o),
    .key_ready_i(key_ready_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .state_o(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0b exp=%0b t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL timeout_%s no event within budget t=%0t", name, $time);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // observations of what the DUT did (for directed literal checks)
  int          n_issue, n_done, n_err, last_pos;
  logic [31:0] got_q[$];
  logic [31:0] idx_q[$];
  logic [255:0] last_hash;

  // behavioural model: one derivation = a list of blocks, each block
  // contributing min(8, words left) words of its hash, MSB word first
  bit          m_busy, m_issue, m_done, m_err, m_waiting;
  logic [255:0] m_pass;
  logic [223:0] m_salt;
  logic [31:0] m_iters, m_blk;
  int          m_left;
  logic [31:0] exp_q[$];

  // sink ready driver
  bit ready_mode = 1'b0;
  initial begin
    key_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      key_ready_i = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // compare process: check outputs against the model, then advance it
  initial begin
    bit ev, i_n, d_n, e_n;
    int n;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        chk1("rst_busy", busy_o, 1'b0);
        chk1("rst_chunk_start", chunk_start_o, 1'b0);
        chk1("rst_chunk_ready", chunk_ready_o, 1'b0);
        chk1("rst_key_valid", key_valid_o, 1'b0);
        chk1("rst_key_last", key_last_o, 1'b0);
        chk1("rst_done", done_o, 1'b0);
        chk1("rst_err", err_o, 1'b0);
        chk32("rst_key_word", key_word_o, 32'd0);
        chk32("rst_iters", chunk_iters_o, 32'd0);
        chkw("rst_salt", chunk_salt_o, 256'd0);
        chkw("rst_pass", chunk_pass_o, 256'd0);
        chk1("rst_state_idle", state_dbg == 3'd0, 1'b1);
        m_busy = 0; m_issue = 0; m_done = 0; m_err = 0; m_waiting = 0;
        m_left = 0; m_blk = 0;
        exp_q.delete();
      end else begin
        ev = (exp_q.size() > 0);
        chk1("busy", busy_o, m_busy);
        chk1("chunk_start", chunk_start_o, m_issue);
        chk1("done", done_o, m_done);
        chk1("err", err_o, m_err);
        chk1("chunk_ready", chunk_ready_o, m_waiting && chunk_valid_i);
        chk1("key_valid", key_valid_o, ev);
        chk1("key_last", key_last_o, ev && (m_left == 1));
        if (ev) chk32("key_word", key_word_o, exp_q[0]);
        if (m_issue) begin
          chkw("issue_salt", chunk_salt_o, {m_salt, m_blk});
          chkw("issue_pass", chunk_pass_o, m_pass);
          chk32("issue_iters", chunk_iters_o, m_iters);
        end
        // observations
        if (chunk_start_o) begin
          n_issue++;
          idx_q.push_back(chunk_salt_o[31:0]);
        end
        if (key_valid_o && key_ready_i) begin
          got_q.push_back(key_word_o);
          if (key_last_o) last_pos = got_q.size();
        end
        if (done_o) n_done++;
        if (err_o) n_err++;
        // advance the model by this cycle's inputs
        i_n = 0; d_n = 0; e_n = 0;
        if (!m_busy && start_i) begin
          if (dklen_i == 8'd0 || int'(dklen_i) > 8 * MAX_BLOCKS || iters_i == 32'd0) begin
            e_n = 1;
          end else begin
            m_busy = 1; m_pass = pass_i; m_salt = salt_i; m_iters = iters_i;
            m_left = int'(dklen_i); m_blk = 32'd1; i_n = 1;
          end
        end
        if (m_done) m_busy = 0;
        if (m_waiting && chunk_valid_i) begin
          m_waiting = 0;
          n = (m_left < 8) ? m_left : 8;
          for (int k = 0; k < n; k++) exp_q.push_back(chunk_hash_i[255-32*k -: 32]);
        end
        if (m_issue) m_waiting = 1;
        if (ev && key_ready_i) begin
          void'(exp_q.pop_front());
          m_left--;
          if (m_left == 0) d_n = 1;
          else if (exp_q.size() == 0) begin
            i_n = 1;
            m_blk = m_blk + 32'd1;
          end
        end
        m_issue = i_n; m_done = d_n; m_err = e_n;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_obs();
    n_issue = 0; n_done = 0; n_err = 0; last_pos = 0;
    got_q.delete();
    idx_q.delete();
  endtask

  task automatic do_start(input logic [31:0] iters, input logic [7:0] dklen, input bit hold);
    logic [255:0] s;
    s = rand256();
    @(posedge clk_i);
    #1;
    pass_i = rand256();
    salt_i = s[223:0];
    iters_i = iters;
    dklen_i = dklen;
    start_i = 1'b1;
    if (!hold) begin
      step();
      start_i = 1'b0;
    end
  endtask

  task automatic serve(input int dklen, input int dmin, input int dmax, input bit fixed,
                       input bit dbl, input int nblk_lim, input bit wait_done);
    int nblk, t;
    nblk = (dklen + 7) / 8;
    if (nblk_lim < nblk) nblk = nblk_lim;
    for (int b = 0; b < nblk; b++) begin
      t = 0;
      while (!chunk_start_o && t < 2000) begin
        step();
        t++;
      end
      if (!chunk_start_o) begin
        timeout("issue");
        return;
      end
      repeat ($urandom_range(dmin, dmax)) step();
      chunk_hash_i = fixed ? FIXED_HASH : rand256();
      last_hash = chunk_hash_i;
      chunk_valid_i = 1'b1;
      step();
      if (dbl) begin
        chunk_hash_i = rand256();
        step();
      end
      chunk_valid_i = 1'b0;
    end
    if (wait_done) begin
      t = 0;
      while (!done_o && t < 2000) begin
        step();
        t++;
      end
      if (!done_o) timeout("done");
    end
  endtask

  // main sequence
  initial begin
    int dk;
    rst_ni = 1'b0; start_i = 1'b0; pass_i = '0; salt_i = '0; iters_i = '0;
    dklen_i = '0; chunk_valid_i = 1'b0; chunk_hash_i = '0;
    clear_obs();
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step();

    // single block, fixed byte-ramp hash
    clear_obs();
    do_start(32'd1, 8'd8, 1'b0);
    serve(8, 1, 3, 1'b1, 1'b0, 99, 1'b1);
    repeat (3) step();
    chk32("t1_issues", n_issue, 32'd1);
    chk32("t1_index", idx_q[0], 32'h00000001);
    chk32("t1_words", got_q.size(), 32'd8);
    chk32("t1_word0", got_q[0], 32'h00010203);
    chk32("t1_word3", got_q[3], 32'h0c0d0e0f);
    chk32("t1_word7", got_q[7], 32'h1c1d1e1f);
    chk32("t1_last_pos", last_pos, 32'd8);
    chk32("t1_done", n_done, 32'd1);

    // three blocks, last truncated; valid held an extra DRAIN cycle
    clear_obs();
    do_start(32'($urandom_range(1, 5000)), 8'd20, 1'b0);
    serve(20, 1, 5, 1'b0, 1'b1, 99, 1'b1);
    repeat (3) step();
    chk32("t2_issues", n_issue, 32'd3);
    chk32("t2_idx1", idx_q[0], 32'd1);
    chk32("t2_idx2", idx_q[1], 32'd2);
    chk32("t2_idx3", idx_q[2], 32'd3);
    chk32("t2_words", got_q.size(), 32'd20);
    chk32("t2_word16", got_q[16], last_hash[255:224]);
    chk32("t2_word19", got_q[19], last_hash[159:128]);
    chk32("t2_last_pos", last_pos, 32'd20);

    // rejected starts plus a stray chunk result while idle
    clear_obs();
    do_start(32'd7, 8'd0, 1'b0);
    step();
    do_start(32'd7, 8'd33, 1'b0);
    step();
    do_start(32'd0, 8'd8, 1'b0);
    chunk_valid_i = 1'b1;
    chunk_hash_i = rand256();
    step();
    chunk_valid_i = 1'b0;
    repeat (3) step();
    chk32("t3_errs", n_err, 32'd3);
    chk32("t3_issues", n_issue, 32'd0);

    // random lengths with random sink stalls; last run waits 50 cycles
    ready_mode = 1'b1;
    for (int r = 0; r < 5; r++) begin
      dk = $urandom_range(1, 32);
      clear_obs();
      do_start(32'($urandom_range(1, 100000)), 8'(dk), 1'b0);
      if (r == 4) serve(dk, 50, 50, 1'b0, 1'b0, 99, 1'b1);
      else serve(dk, 1, 12, 1'b0, r[0], 99, 1'b1);
      repeat (2) step();
      chk32("t4_words", got_q.size(), 32'(dk));
      chk32("t4_last_pos", last_pos, 32'(dk));
      chk32("t4_issues", n_issue, 32'((dk + 7) / 8));
    end

    // reset during DRAIN of block 2
    clear_obs();
    do_start(32'd3, 8'd16, 1'b0);
    serve(16, 1, 4, 1'b0, 1'b0, 2, 1'b0);
    step();
    rst_ni = 1'b0;
    #1;
    chk1("t5_rst_busy_now", busy_o, 1'b0);
    chk1("t5_rst_valid_now", key_valid_o, 1'b0);
    chk32("t5_rst_word_now", key_word_o, 32'd0);
    chkw("t5_rst_salt_now", chunk_salt_o, 256'd0);
    repeat (2) step();
    rst_ni = 1'b1;
    chunk_valid_i = 1'b1;
    chunk_hash_i = rand256();
    step();
    chunk_valid_i = 1'b0;
    step();
    chk32("t5_no_done", n_done, 32'd0);
    clear_obs();
    do_start(32'd9, 8'd16, 1'b0);
    serve(16, 1, 4, 1'b0, 1'b0, 99, 1'b1);
    repeat (2) step();
    chk32("t5_idx1", idx_q[0], 32'd1);
    chk32("t5_words", got_q.size(), 32'd16);
    chk32("t5_done", n_done, 32'd1);

    // start held high across two derivations
    clear_obs();
    do_start(32'd2, 8'd12, 1'b1);
    serve(12, 1, 4, 1'b0, 1'b0, 99, 1'b1);
    serve(12, 1, 4, 1'b0, 1'b0, 99, 1'b1);
    start_i = 1'b0;
    repeat (4) step();
    chk32("t6_issues", n_issue, 32'd4);
    chk32("t6_done", n_done, 32'd2);
    chk32("t6_errs", n_err, 32'd0);
    chk32("t6_words", got_q.size(), 32'd24);

    // start on the first edge after reset release
    rst_ni = 1'b0;
    repeat (2) step();
    rst_ni = 1'b1;
    pass_i = rand256();
    iters_i = 32'd1;
    dklen_i = 8'd4;
    start_i = 1'b1;
    clear_obs();
    step();
    start_i = 1'b0;
    chk1("t7_issue_first_edge", chunk_start_o, 1'b1);
    serve(4, 1, 3, 1'b0, 1'b0, 99, 1'b1);
    repeat (2) step();
    chk32("t7_words", got_q.size(), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
